// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// alu_seq_ctrl : command sequencer driving a 16-bit ripple ALU (1-cycle ops,
//                16-step shift-add multiply), registered result + NZCV flags
// Revision     : 1.0
// ============================================================================
`default_nettype none

module alu_seq_ctrl #(
   parameter int WIDTH     = 16,
   parameter int MUL_STEPS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [2:0]       i_req_cmd,
   input  logic [WIDTH-1:0] i_req_a,
   input  logic [WIDTH-1:0] i_req_b,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_rsp_result,
   output logic [3:0]       o_rsp_flags,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic             o_alu_cin,
   output logic             o_alu_ainvert,
   output logic             o_alu_bnegate,
   output logic [2:0]       o_alu_op,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic             i_alu_cout
);

   localparam logic [2:0] c_CMD_ADD = 3'b000;
   localparam logic [2:0] c_CMD_SUB = 3'b001;
   localparam logic [2:0] c_CMD_AND = 3'b010;
   localparam logic [2:0] c_CMD_OR  = 3'b011;
   localparam logic [2:0] c_CMD_XOR = 3'b100;
   localparam logic [2:0] c_CMD_CMP = 3'b101;
   localparam logic [2:0] c_CMD_NEG = 3'b110;
   localparam logic [2:0] c_CMD_MUL = 3'b111;

   localparam logic [2:0] c_OP_AND = 3'b000;
   localparam logic [2:0] c_OP_OR  = 3'b001;
   localparam logic [2:0] c_OP_ADD = 3'b010;
   localparam logic [2:0] c_OP_XOR = 3'b011;

   localparam int                c_CNT_W    = $clog2(MUL_STEPS);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_cmd;
   logic [WIDTH-1:0]   r_a;       // operand A, doubles as multiplicand
   logic [WIDTH-1:0]   r_b;       // operand B, doubles as multiplier
   logic [WIDTH-1:0]   r_acc;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic [3:0]         r_flags;

   logic [WIDTH-1:0]   w_exec_result;
   logic [3:0]         w_exec_flags;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic               w_zero, w_r15, w_x15, w_y15, w_v_add, w_v_sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      o_alu_a       = '0;
      o_alu_b       = '0;
      o_alu_cin     = 1'b0;
      o_alu_ainvert = 1'b0;
      o_alu_bnegate = 1'b0;
      o_alu_op      = c_OP_AND;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid)
               w_state_nxt = (i_req_cmd == c_CMD_MUL) ? S_MUL : S_EXEC;
         end
         S_EXEC: begin
            w_state_nxt = S_DONE;
            o_alu_a     = r_a;
            o_alu_b     = r_b;
            case (r_cmd)
               c_CMD_ADD: o_alu_op = c_OP_ADD;
               c_CMD_SUB, c_CMD_CMP: begin
                  o_alu_op      = c_OP_ADD;
                  o_alu_bnegate = 1'b1;
                  o_alu_cin     = 1'b1;
               end
               c_CMD_NEG: begin
                  o_alu_a       = '0;
                  o_alu_op      = c_OP_ADD;
                  o_alu_bnegate = 1'b1;
                  o_alu_cin     = 1'b1;
               end
               c_CMD_OR:  o_alu_op = c_OP_OR;
               c_CMD_XOR: o_alu_op = c_OP_XOR;
               default:   o_alu_op = c_OP_AND;
            endcase
         end
         S_MUL: begin
            o_alu_a  = r_acc;
            o_alu_b  = r_a;
            o_alu_op = c_OP_ADD;
            if (r_cnt == c_CNT_LAST) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (i_rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // x is the minuend (0 for NEG), y the subtrahend; ADD reuses the same pair
   assign w_r15   = i_alu_result[WIDTH-1];
   assign w_x15   = o_alu_a[WIDTH-1];
   assign w_y15   = r_b[WIDTH-1];
   assign w_zero  = (i_alu_result == '0);
   assign w_v_add = (w_x15 == w_y15) && (w_r15 != w_x15);
   assign w_v_sub = (w_x15 != w_y15) && (w_r15 != w_x15);

   always_comb begin
      w_exec_result = i_alu_result;
      w_exec_flags  = {w_r15, w_zero, 2'b00};
      case (r_cmd)
         c_CMD_ADD: w_exec_flags = {w_r15, w_zero, i_alu_cout, w_v_add};
         c_CMD_SUB, c_CMD_NEG:
                    w_exec_flags = {w_r15, w_zero, i_alu_cout, w_v_sub};
         c_CMD_CMP: begin
            w_exec_result = r_a;
            w_exec_flags  = {w_r15, w_zero, i_alu_cout, w_v_sub};
         end
         default: ;
      endcase
   end

   assign w_acc_nxt = r_b[0] ? i_alu_result : r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_cmd <= i_req_cmd;
                  r_a   <= i_req_a;
                  r_b   <= i_req_b;
                  r_acc <= '0;
                  r_cnt <= '0;
               end
            end
            S_EXEC: begin
               r_result <= w_exec_result;
               r_flags  <= w_exec_flags;
            end
            S_MUL: begin
               r_acc <= w_acc_nxt;
               r_a   <= r_a << 1;
               r_b   <= r_b >> 1;
               r_cnt <= r_cnt + c_CNT_W'(1);
               if (r_cnt == c_CNT_LAST) begin
                  r_result <= w_acc_nxt;
                  r_flags  <= {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), 2'b00};
               end
            end
            default: ;
         endcase
      end
   end

   assign o_req_ready  = (r_state == S_IDLE);
   assign o_rsp_valid  = (r_state == S_DONE);
   assign o_rsp_result = r_result;
   assign o_rsp_flags  = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// tb_alu_seq_ctrl : directed self-checking bench with a behavioural ripple ALU
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_cmd = '0;
   logic [15:0] req_a = '0;
   logic [15:0] req_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [15:0] alu_a, alu_b, alu_result;
   logic        alu_cin, alu_ainvert, alu_bnegate, alu_cout;
   logic [2:0]  alu_op;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Behavioural model of the downstream ALU
   logic [15:0] m_a, m_b;
   logic [16:0] m_sum;
   always_comb begin
      m_a   = alu_ainvert ? ~alu_a : alu_a;
      m_b   = alu_bnegate ? ~alu_b : alu_b;
      m_sum = {1'b0, m_a} + {1'b0, m_b} + {16'd0, alu_cin};
      alu_cout = m_sum[16];
      case (alu_op)
         3'b000:  alu_result = m_a & m_b;
         3'b001:  alu_result = m_a | m_b;
         3'b010:  alu_result = m_sum[15:0];
         3'b011:  alu_result = m_a ^ m_b;
         default: alu_result = 16'h0000;
      endcase
   end

   alu_seq_ctrl #(.WIDTH(16), .MUL_STEPS(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_cmd     (req_cmd),
      .i_req_a       (req_a),
      .i_req_b       (req_b),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_result  (rsp_result),
      .o_rsp_flags   (rsp_flags),
      .o_alu_a       (alu_a),
      .o_alu_b       (alu_b),
      .o_alu_cin     (alu_cin),
      .o_alu_ainvert (alu_ainvert),
      .o_alu_bnegate (alu_bnegate),
      .o_alu_op      (alu_op),
      .i_alu_result  (alu_result),
      .i_alu_cout    (alu_cout)
   );

   // Issue one command, count edges from accept to rsp_valid, then handshake.
   task automatic run_cmd(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic [3:0] flg, output int lat);
      int guard = 0;
      while (!req_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      req_cmd = cmd; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      res = rsp_result;
      flg = rsp_flags;
      if (!rsp_valid) begin
         tests++; fails++;
         $display("FAIL timeout cmd=%0d: rsp_valid never rose within %0d edges", cmd, lat);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", rsp_valid); end
      tests++; if (rsp_result !== 16'h0 || rsp_flags !== 4'h0) begin fails++;
         $display("FAIL reset_result: got %h/%b exp 0000/0000", rsp_result, rsp_flags); end
      tests++; if ({alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_op} !== '0) begin fails++;
         $display("FAIL reset_alu: got a=%h b=%h op=%b exp all zero", alu_a, alu_b, alu_op); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
   endtask

   task automatic test_arith;
      logic [15:0] r; logic [3:0] f; int l;
      run_cmd(3'b000, 16'h7FFF, 16'h0001, r, f, l);
      tests++; if (r !== 16'h8000) begin fails++; $display("FAIL add_result: got %h exp 8000", r); end
      tests++; if (f !== 4'b1001) begin fails++; $display("FAIL add_flags: got %b exp 1001", f); end
      tests++; if (l !== 2) begin fails++; $display("FAIL add_latency: got %0d exp 2", l); end
      run_cmd(3'b001, 16'h0005, 16'h0005, r, f, l);
      tests++; if (r !== 16'h0000) begin fails++; $display("FAIL sub_result: got %h exp 0000", r); end
      tests++; if (f !== 4'b0110) begin fails++; $display("FAIL sub_flags: got %b exp 0110", f); end
      run_cmd(3'b101, 16'h0003, 16'h0007, r, f, l);
      tests++; if (r !== 16'h0003) begin fails++; $display("FAIL cmp_result: got %h exp 0003", r); end
      tests++; if (f !== 4'b1000) begin fails++; $display("FAIL cmp_flags: got %b exp 1000", f); end
      run_cmd(3'b110, 16'h0000, 16'h8000, r, f, l);
      tests++; if (r !== 16'h8000) begin fails++; $display("FAIL neg_result: got %h exp 8000", r); end
      tests++; if (f !== 4'b1001) begin fails++; $display("FAIL neg_flags: got %b exp 1001", f); end
      run_cmd(3'b110, 16'h1234, 16'h0001, r, f, l);
      tests++; if (r !== 16'hFFFF || f !== 4'b1000) begin fails++;
         $display("FAIL neg_one: got %h/%b exp ffff/1000", r, f); end
   endtask

   task automatic test_logic;
      logic [15:0] r; logic [3:0] f; int l;
      run_cmd(3'b010, 16'hF0F0, 16'h0FF0, r, f, l);
      tests++; if (r !== 16'h00F0 || f !== 4'b0000) begin fails++;
         $display("FAIL and: got %h/%b exp 00f0/0000", r, f); end
      run_cmd(3'b011, 16'h1200, 16'h8034, r, f, l);
      tests++; if (r !== 16'h9234 || f !== 4'b1000) begin fails++;
         $display("FAIL or: got %h/%b exp 9234/1000", r, f); end
      run_cmd(3'b100, 16'hAAAA, 16'hFFFF, r, f, l);
      tests++; if (r !== 16'h5555 || f !== 4'b0000) begin fails++;
         $display("FAIL xor: got %h/%b exp 5555/0000", r, f); end
      tests++; if (l !== 2) begin fails++; $display("FAIL xor_latency: got %0d exp 2", l); end
   endtask

   task automatic test_mul;
      logic [15:0] r; logic [3:0] f; int l;
      run_cmd(3'b111, 16'h00FF, 16'h0101, r, f, l);
      tests++; if (r !== 16'hFFFF || f !== 4'b1000) begin fails++;
         $display("FAIL mul_ff: got %h/%b exp ffff/1000", r, f); end
      tests++; if (l !== 17) begin fails++; $display("FAIL mul_latency: got %0d exp 17", l); end
      run_cmd(3'b111, 16'h1234, 16'h0000, r, f, l);
      tests++; if (r !== 16'h0000 || f !== 4'b0100) begin fails++;
         $display("FAIL mul_zero: got %h/%b exp 0000/0100", r, f); end
      run_cmd(3'b111, 16'h0300, 16'h8101, r, f, l);
      tests++; if (r !== 16'h0300 || f !== 4'b0000) begin fails++;
         $display("FAIL mul_wrap: got %h/%b exp 0300/0000", r, f); end
   endtask

   task automatic test_mid_reset;
      logic [15:0] r; logic [3:0] f; int l;
      req_cmd = 3'b111; req_a = 16'h00FF; req_b = 16'h0101; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests++; if (rsp_valid !== 1'b0 || rsp_result !== 16'h0 || rsp_flags !== 4'h0) begin fails++;
         $display("FAIL midreset_out: got v=%b r=%h f=%b exp 0/0000/0000", rsp_valid, rsp_result, rsp_flags); end
      tests++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 3'b000) begin fails++;
         $display("FAIL midreset_alu: got a=%h b=%h op=%b exp 0/0/000", alu_a, alu_b, alu_op); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b exp 1", req_ready); end
      run_cmd(3'b000, 16'h0001, 16'h0001, r, f, l);
      tests++; if (r !== 16'h0002 || f !== 4'b0000) begin fails++;
         $display("FAIL midreset_add: got %h/%b exp 0002/0000", r, f); end
   endtask

   task automatic test_backpressure;
      req_cmd = 3'b000; req_a = 16'h0010; req_b = 16'h0020; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b exp 1", rsp_valid); end
      req_cmd = 3'b100; req_a = 16'hFFFF; req_b = 16'h0000; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         tests++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h0030 || req_ready !== 1'b0) begin fails++;
            $display("FAIL bp_hold[%0d]: got v=%b r=%h rdy=%b exp 1/0030/0", i, rsp_valid, rsp_result, req_ready); end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++;
         $display("FAIL bp_release: got v=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
      req_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_result !== 16'h0030) begin fails++;
         $display("FAIL bp_ignored: got v=%b rdy=%b r=%h exp 0/1/0030", rsp_valid, req_ready, rsp_result); end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic();
      test_mul();
      test_mid_reset();
      test_backpressure();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
